// File: rtl/traffic_light_multi.sv
// Multi-approach traffic-light controller: cycles NUM_DIR approaches through
// green, yellow and all-red clearance. With SKIP_IDLE=1, approaches that show
// no demand are skipped, and green is held while no other approach is waiting.
module traffic_light_multi #(
  parameter int NUM_DIR     = 2,
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W       = 8,
  parameter int SKIP_IDLE   = 0,
  localparam int DIR_W      = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_DIR-1:0]   sensor,
  output logic [3*NUM_DIR-1:0] lights,
  output logic [DIR_W-1:0]     active_dir,
  output logic [1:0]           phase
);

  localparam int unsigned N = NUM_DIR;

  typedef enum logic [1:0] {
    ALLRED = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [DIR_W-1:0] dir_nxt;
  logic [DIR_W-1:0] rr_dir;
  logic             rr_found;
  logic             others_wait;
  int unsigned      idx;

  // Demand scan: first requesting approach after active_dir (active_dir is
  // checked last), and whether any approach other than active_dir is waiting.
  always_comb begin
    rr_dir      = active_dir;
    rr_found    = 1'b0;
    others_wait = 1'b0;
    idx         = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(active_dir) + i) % N;
      if (!rr_found && sensor[DIR_W'(idx)]) begin
        rr_dir   = DIR_W'(idx);
        rr_found = 1'b1;
      end
    end
    for (int unsigned d = 0; d < N; d++) begin
      if (DIR_W'(d) != active_dir && sensor[DIR_W'(d)]) others_wait = 1'b1;
    end
  end

  // Next-state logic: timer counts down and the phase changes when it reaches zero.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer - CNT_W'(1);
    dir_nxt   = active_dir;
    if (timer == '0) begin
      case (state)
        ALLRED: begin
          if (SKIP_IDLE == 0) begin
            dir_nxt   = (active_dir == DIR_W'(NUM_DIR - 1)) ? '0 : active_dir + DIR_W'(1);
            state_nxt = GREEN;
            timer_nxt = CNT_W'(GREEN_TIME - 1);
          end else if (rr_found) begin
            dir_nxt   = rr_dir;
            state_nxt = GREEN;
            timer_nxt = CNT_W'(GREEN_TIME - 1);
          end else begin
            // No demand anywhere: park in all-red and re-evaluate every cycle.
            timer_nxt = '0;
          end
        end
        GREEN: begin
          if (SKIP_IDLE != 0 && !others_wait) begin
            timer_nxt = CNT_W'(GREEN_TIME - 1);
          end else begin
            state_nxt = YELLOW;
            timer_nxt = CNT_W'(YELLOW_TIME - 1);
          end
        end
        YELLOW: begin
          state_nxt = ALLRED;
          timer_nxt = CNT_W'(ALLRED_TIME - 1);
        end
        default: begin
          state_nxt = ALLRED;
          timer_nxt = CNT_W'(ALLRED_TIME - 1);
        end
      endcase
    end
  end

  // State, timer and owning approach; reset parks in all-red ahead of approach 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ALLRED;
      timer      <= CNT_W'(ALLRED_TIME - 1);
      active_dir <= DIR_W'(NUM_DIR - 1);
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      active_dir <= dir_nxt;
    end
  end

  // Lamp decode from registered state only; non-owning approaches show red.
  always_comb begin
    lights = '0;
    phase  = state;
    for (int unsigned d = 0; d < N; d++) begin
      lights[3*d +: 3] = 3'b100;
      if (DIR_W'(d) == active_dir) begin
        if (state == GREEN)  lights[3*d +: 3] = 3'b001;
        if (state == YELLOW) lights[3*d +: 3] = 3'b010;
      end
    end
  end

endmodule
